// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetches at the PC, buffers the returned
// instruction for decode and decides when and where the PC is written.
module pc_sequencer #(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int STEP = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_value,
    output logic            pc_wen,
    output logic [XLEN-1:0] pc_wdata,
    output logic            if_req_valid,
    output logic [XLEN-1:0] if_req_addr,
    input  logic            if_req_ready,
    input  logic            if_resp_valid,
    input  logic [ILEN-1:0] if_resp_inst,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            halt,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DELIVER = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]   pend_target_q, pend_target_d;
    logic [ILEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;

    logic              redirect;
    logic [XLEN-1:0]   sel_target;
    logic [XLEN-1:0]   wr_target;

    // Trap/mret outranks an ordinary branch/jump redirect.
    assign redirect   = trap_valid | redir_valid;
    assign sel_target = trap_valid ? trap_target : redir_target;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            inst_q        <= '0;
            inst_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        case (state_q)
            S_FETCH: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (!redirect && if_req_ready) begin
                    state_d   = S_WAIT;
                    inst_pc_d = pc_value;
                end
            end
            S_WAIT: begin
                if (halt) begin
                    state_d      = S_HALT;
                    pend_valid_d = 1'b0;
                end else if (if_resp_valid) begin
                    pend_valid_d = 1'b0;
                    if (pend_valid_q || redirect) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DELIVER;
                        inst_d  = if_resp_inst;
                    end
                end else if (redirect) begin
                    // Latest redirect wins while the fetch is still in flight.
                    pend_valid_d  = 1'b1;
                    pend_target_d = sel_target;
                end
            end
            S_DELIVER: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (redirect || inst_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc_wen       = 1'b0;
        wr_target    = '0;
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        inst_valid   = 1'b0;
        inst         = '0;
        inst_pc      = '0;
        halted       = 1'b0;
        if (!reset) begin
            if (state_q == S_HALT) begin
                halted = 1'b1;
            end else begin
                if_req_addr = pc_value;
                inst        = inst_q;
                inst_pc     = inst_pc_q;
            end
            case (state_q)
                S_FETCH: begin
                    if (!halt) begin
                        if (redirect) begin
                            pc_wen    = 1'b1;
                            wr_target = sel_target;
                        end else begin
                            if_req_valid = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!halt && if_resp_valid && (pend_valid_q || redirect)) begin
                        pc_wen    = 1'b1;
                        wr_target = redirect ? sel_target : pend_target_q;
                    end
                end
                S_DELIVER: begin
                    // A squashed instruction never presents valid, so no handshake occurs.
                    inst_valid = !halt && !redirect;
                    if (!halt) begin
                        if (redirect) begin
                            pc_wen    = 1'b1;
                            wr_target = sel_target;
                        end else if (inst_ready) begin
                            pc_wen    = 1'b1;
                            wr_target = inst_pc_q + XLEN'(STEP);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_wdata = wr_target & ~XLEN'(3);

endmodule

// File: tb/tb_pc_sequencer.sv
// Cycle-by-cycle directed bench for pc_sequencer with a behavioural PC register.
module tb_pc_sequencer;

    localparam logic [63:0] B   = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADI = 32'h0010_0093;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] pc_value;
    logic        pc_wen;
    logic [63:0] pc_wdata;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        redir_valid;
    logic [63:0] redir_target;
    logic        trap_valid;
    logic [63:0] trap_target;
    logic        halt;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pc_sequencer #(.XLEN(64), .ILEN(32), .STEP(4)) dut (
        .clock(clock), .reset(reset), .pc_value(pc_value),
        .pc_wen(pc_wen), .pc_wdata(pc_wdata),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .halt(halt), .halted(halted)
    );

    // The PC register the sequencer controls.
    initial pc_value = B;
    always_ff @(posedge clock) begin
        if (reset)       pc_value <= B;
        else if (pc_wen) pc_value <= pc_wdata;
    end

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] ri;
        logic        irdy, rdv;
        logic [63:0] rdt;
        logic        tv;
        logic [63:0] tt;
        logic        hlt;
        logic        e_wen;
        logic [63:0] e_wdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_ipc;
        logic        e_halted;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, rdy, rv, input logic [31:0] ri,
                       input logic irdy, rdv, input logic [63:0] rdt,
                       input logic tv, input logic [63:0] tt, input logic hlt,
                       input logic e_wen, input logic [63:0] e_wdata,
                       input logic e_req, input logic [63:0] e_addr,
                       input logic e_iv, input logic [31:0] e_inst,
                       input logic [63:0] e_ipc, input logic e_halted);
        vec_t v;
        v = '{rst, rdy, rv, ri, irdy, rdv, rdt, tv, tt, hlt,
              e_wen, e_wdata, e_req, e_addr, e_iv, e_inst, e_ipc, e_halted};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive after the edge, sample mid-cycle; the next posedge commits the cycle.
    task automatic run_vec(input int idx, input vec_t v);
        @(posedge clock);
        #1;
        reset         = v.rst;
        if_req_ready  = v.rdy;
        if_resp_valid = v.rv;
        if_resp_inst  = v.ri;
        inst_ready    = v.irdy;
        redir_valid   = v.rdv;
        redir_target  = v.rdt;
        trap_valid    = v.tv;
        trap_target   = v.tt;
        halt          = v.hlt;
        @(negedge clock);
        $display("cycle %0d: wen=%0b wdata=%h req=%0b addr=%h iv=%0b inst=%h ipc=%h halted=%0b",
                 idx, pc_wen, pc_wdata, if_req_valid, if_req_addr, inst_valid, inst, inst_pc, halted);
        chk("pc_wen", 64'(pc_wen), 64'(v.e_wen));
        if (v.e_wen) chk("pc_wdata", pc_wdata, v.e_wdata);
        chk("if_req_valid", 64'(if_req_valid), 64'(v.e_req));
        if (v.e_req) chk("if_req_addr", if_req_addr, v.e_addr);
        chk("inst_valid", 64'(inst_valid), 64'(v.e_iv));
        if (v.e_iv) begin
            chk("inst", 64'(inst), 64'(v.e_inst));
            chk("inst_pc", inst_pc, v.e_ipc);
        end
        chk("halted", 64'(halted), 64'(v.e_halted));
    endtask

    initial begin
        reset = 1'b1; if_req_ready = 0; if_resp_valid = 0; if_resp_inst = '0;
        inst_ready = 0; redir_valid = 0; redir_target = '0; trap_valid = 0;
        trap_target = '0; halt = 0;

        //  rst rdy rv ri   irdy rdv rdt            tv tt            hlt | wen wdata          req addr           iv inst ipc      hlt
        // sequential advance
        add(1, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 1, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, B,             0, 0,   0,      0);
        add(0, 0, 1, NOP, 0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   1, 0, 0,             0, 0,             0,  1, B+4,           0, 0,             1, NOP, B,      0);
        add(0, 1, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, B+4,           0, 0,   0,      0);
        add(0, 0, 1, NOP, 0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   1, 0, 0,             0, 0,             0,  1, B+8,           0, 0,             1, NOP, B+4,    0);
        // redirect while the instruction is held in DELIVER (misaligned target)
        add(0, 1, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, B+8,           0, 0,   0,      0);
        add(0, 0, 1, ADI, 0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             1, ADI, B+8,    0);
        add(0, 0, 0, 0,   0, 1, 64'h80001002,  0, 0,             0,  1, 64'h80001000,  0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, 64'h80001000,  0, 0,   0,      0);
        // two redirects while waiting: latest (trap) wins, response discarded
        add(0, 1, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, 64'h80001000,  0, 0,   0,      0);
        add(0, 0, 0, 0,   0, 1, 64'h80002000,  0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   0, 0, 0,             1, 64'h80003000,  0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 1, NOP, 0, 0, 0,             0, 0,             0,  1, 64'h80003000,  0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, 64'h80003000,  0, 0,   0,      0);
        // trap and branch in the same FETCH cycle
        add(0, 1, 0, 0,   0, 1, 64'h80005000,  1, 64'h80004000,  0,  1, 64'h80004000,  0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, 64'h80004000,  0, 0,   0,      0);
        // sequential advance wraps past the top of the address space
        add(0, 0, 0, 0,   0, 1, TOP,           0, 0,             0,  1, TOP,           0, 0,             0, 0,   0,      0);
        add(0, 1, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, TOP,           0, 0,   0,      0);
        add(0, 0, 1, NOP, 0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   1, 0, 0,             0, 0,             0,  1, 0,             0, 0,             1, NOP, TOP,    0);
        add(0, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, 0,             0, 0,   0,      0);
        // halt beats a same-cycle redirect; HALT ignores traffic until reset
        add(0, 0, 0, 0,   0, 1, 64'h80006000,  0, 0,             1,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 1, 1, NOP, 1, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      1);
        add(0, 0, 0, 0,   0, 1, 64'h80006000,  0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      1);
        add(1, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, B,             0, 0,   0,      0);
        // reset abandons an outstanding fetch; late response is ignored
        add(0, 1, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, B,             0, 0,   0,      0);
        add(1, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 1, NOP, 1, 0, 0,             0, 0,             0,  0, 0,             1, B,             0, 0,   0,      0);
        add(0, 0, 0, 0,   1, 0, 0,             0, 0,             0,  0, 0,             1, B,             0, 0,   0,      0);

        for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

        // Hand sequence: redirect coinciding with the response, then halt in DELIVER.
        vq.delete();
        add(0, 1, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, B,             0, 0,   0,      0);
        add(0, 0, 1, ADI, 0, 1, 64'h80007000,  0, 0,             0,  1, 64'h80007000,  0, 0,             0, 0,   0,      0);
        add(0, 1, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             1, 64'h80007000,  0, 0,   0,      0);
        add(0, 0, 1, NOP, 0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   0, 0, 0,             0, 0,             0,  0, 0,             0, 0,             1, NOP, 64'h80007000, 0);
        add(0, 0, 0, 0,   1, 0, 0,             0, 0,             1,  0, 0,             0, 0,             0, 0,   0,      0);
        add(0, 0, 0, 0,   1, 0, 0,             0, 0,             0,  0, 0,             0, 0,             0, 0,   0,      1);
        for (int i = 0; i < vq.size(); i++) run_vec(100 + i, vq[i]);

        // The PC register must still hold the last written target after HALT.
        chk("pc_after_halt", pc_value, 64'h80007000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the 64-bit program-counter register of the NPC core: decides when the PC is written and with what value.
- Issues instruction-fetch requests at the current PC and buffers the returned instruction for decode.
- Arbitrates between sequential advance (+4), branch/jump redirect and trap/mret redirect.
- Sits between the PC register, the instruction-fetch port and the decode stage.

Parameters:
XLEN, 64, PC / address width in bits
ILEN, 32, instruction width in bits
STEP, 4, byte increment for sequential advance

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pc_value  in  XLEN  current PC register output (resets to 0x80000000)
pc_wen  out  1  PC register write enable
pc_wdata  out  XLEN  next PC value
if_req_valid  out  1  fetch request valid
if_req_addr  out  XLEN  fetch address (= pc_value)
if_req_ready  in  1  fetch port accepts request
if_resp_valid  in  1  fetched instruction returned (one-cycle pulse)
if_resp_inst  in  ILEN  fetched instruction
inst_valid  out  1  instruction valid to decode
inst  out  ILEN  buffered instruction
inst_pc  out  XLEN  PC of buffered instruction
inst_ready  in  1  decode accepts instruction
redir_valid  in  1  branch/jump redirect
redir_target  in  XLEN  redirect target
trap_valid  in  1  trap/mret redirect
trap_target  in  XLEN  trap/mret target (mtvec/mepc)
halt  in  1  stop sequencing (ebreak)
halted  out  1  sequencer is in HALT

Behaviour:
- Clock is clock; reset is reset, synchronous, active-high.
- States: FETCH, WAIT, DELIVER, HALT. Reset state is FETCH.
- Reset values: pc_wen=0, if_req_valid=0, inst_valid=0, halted=0, pend_valid=0, inst/inst_pc buffers=0. Outputs are forced low during the reset cycle.
- Redirect selection: when both are asserted in the same cycle, trap_valid beats redir_valid. The selected target is sel_target.
- Target alignment: pc_wdata[1:0] is always forced to 0.
- FETCH:
  - if_req_valid=1 and if_req_addr=pc_value.
  - If if_req_ready is high, go to WAIT and latch inst_pc=pc_value.
  - A redirect in FETCH writes the PC (pc_wen=1, pc_wdata=sel_target) and stays in FETCH; no request is accepted that cycle (if_req_valid=0).
- WAIT:
  - No new request is issued.
  - A redirect sets pend_valid=1 and pend_target=sel_target; a later redirect overwrites it (latest wins).
  - On if_resp_valid with pend_valid=0: latch inst=if_resp_inst and go to DELIVER.
  - On if_resp_valid with pend_valid=1: discard the response, pc_wen=1, pc_wdata=pend_target, clear pend_valid, go to FETCH.
  - A redirect in the same cycle as if_resp_valid uses the new sel_target in place of pend_target.
- DELIVER:
  - inst_valid=1, holding inst and inst_pc stable until accepted.
  - On inst_valid&&inst_ready with no redirect: pc_wen=1, pc_wdata=inst_pc+STEP (modulo 2^XLEN, wraps), go to FETCH.
  - On a redirect, regardless of inst_ready: the instruction is squashed (no handshake counted), pc_wen=1, pc_wdata=sel_target, go to FETCH.
- pc_wen is a single-cycle pulse and is asserted at most once per state transition. The PC register updates on the same edge the state leaves.
- halt:
  - From any state, halt goes to HALT next cycle and overrides any redirect or advance in that cycle (no PC write).
  - In HALT: halted=1, all other outputs 0, responses ignored. Exit is by reset only.
- Reset mid-operation: an outstanding fetch is abandoned and a late if_resp_valid in FETCH is ignored.
- Latency: minimum 3 cycles per instruction (FETCH→WAIT→DELIVER) with a 1-cycle fetch response.

Test Plan:
- Sequential: reset, if_req_ready=1, response 1 cycle later with inst 0x00000013, inst_ready=1 → if_req_addr 0x80000000 then 0x80000004; pc_wen pulses with pc_wdata=0x80000004, 0x80000008.
- Redirect in DELIVER: inst held, inst_ready=0, redir_valid with target 0x80001002 → inst_valid drops, pc_wdata=0x80001000, next if_req_addr=0x80001000.
- Redirect in WAIT: redir 0x80002000 then trap 0x80003000 before response → response discarded, pc_wdata=0x80003000, no inst_valid.
- Simultaneous trap and redir in FETCH (0x80004000 vs 0x80005000) → pc_wdata=0x80004000.
- Wrap: pc_value=0xFFFFFFFFFFFFFFFC delivered → pc_wdata=0x0.
- halt with redir the same cycle → no pc_wen, halted=1 persists; reset → FETCH at 0x80000000.
